// File: rtl/maskbus_pkg.sv
// Shared definitions for the masked 9-bit bus: word width, PRBS9 taps,
// default seed and sync word, mask step function and receiver state enum.
package maskbus_pkg;

  localparam int unsigned W      = 9;
  localparam int unsigned TAP_HI = 8;
  localparam int unsigned TAP_LO = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [W-1:0] DEFAULT_SEED      = 9'h087;
  localparam logic [W-1:0] DEFAULT_SYNC_WORD = 9'h1FF;

  typedef enum logic {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  // One step of x^9 + x^5 + 1: shift left, feed back tap 8 xor tap 4.
  function automatic logic [W-1:0] prbs9_next(input logic [W-1:0] mask);
    return {mask[W-2:0], mask[TAP_HI] ^ mask[TAP_LO]};
  endfunction

endpackage

// File: rtl/prbs9_gen.sv
// PRBS9 mask register. Reloads SEED on load (priority) and steps on advance.
// Ports: clk, reset_n (sync, active low), load, advance, mask (current value).
module prbs9_gen
  import maskbus_pkg::*;
#(
  parameter logic [W-1:0] SEED = DEFAULT_SEED
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         advance,
  output logic [W-1:0] mask
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mask <= SEED;
    end else if (load) begin
      mask <= SEED;
    end else if (advance) begin
      mask <= prbs9_next(mask);
    end
  end

endmodule

// File: rtl/lfsr_unmask.sv
// Receive-side unmasker: hunts for a raw sync word, then XORs the following
// FRAME_LEN words with a rolling PRBS9 mask and forwards them on a
// valid/ready stream through a single output register.
// Ports: i_clk, i_reset_n (sync, active low); upstream i_valid/i_data/o_ready;
// downstream o_valid/o_data/o_last/i_ready; o_locked status.
module lfsr_unmask
  import maskbus_pkg::*;
#(
  parameter logic [W-1:0] SYNC_WORD = DEFAULT_SYNC_WORD,
  parameter logic [W-1:0] SEED      = DEFAULT_SEED,
  parameter int unsigned  FRAME_LEN = 4
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic         i_valid,
  input  logic [W-1:0] i_data,
  output logic         o_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_last,
  input  logic         i_ready,
  output logic         o_locked
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [W-1:0]     mask;
  logic             mask_load, mask_advance;
  logic             valid_d, last_d;
  logic [W-1:0]     data_d;
  logic             accept;

  // Single output register with no skid: accept whenever it is free or draining.
  assign o_ready  = !o_valid || i_ready;
  assign accept   = i_valid && o_ready;
  assign o_locked = (state_q == LOCKED);

  prbs9_gen #(
    .SEED(SEED)
  ) u_prbs9 (
    .clk    (i_clk),
    .reset_n(i_reset_n),
    .load   (mask_load),
    .advance(mask_advance),
    .mask   (mask)
  );

  // State, counter and output register.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state_q <= HUNT;
      count_q <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      o_valid <= valid_d;
      o_data  <= data_d;
      o_last  <= last_d;
    end
  end

  // Next-state, mask control and output-register load.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    mask_load    = 1'b0;
    mask_advance = 1'b0;
    valid_d      = o_valid;
    data_d       = o_data;
    last_d       = o_last;

    // Drain first; a load below overrides it so there is no bubble.
    if (o_valid && i_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    unique case (state_q)
      HUNT: begin
        if (accept && (i_data == SYNC_WORD)) begin
          state_d   = LOCKED;
          count_d   = '0;
          mask_load = 1'b1;
        end
      end
      LOCKED: begin
        if (accept) begin
          valid_d      = 1'b1;
          data_d       = i_data ^ mask;
          last_d       = (count_q == LAST_IDX);
          mask_advance = 1'b1;
          count_d      = count_q + CNT_W'(1);
          if (count_q == LAST_IDX) begin
            state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

endmodule

// File: tb/tb_lfsr_unmask.sv
// Directed bench for lfsr_unmask: a table of per-cycle vectors plus a
// hand-written backpressure sequence.
module tb_lfsr_unmask;

  logic       clk;
  logic       reset_n;
  logic       valid_in;
  logic [8:0] data_in;
  logic       ready_out;
  logic       valid_out;
  logic [8:0] data_out;
  logic       last_out;
  logic       ready_in;
  logic       locked;

  int n_cmp;
  int n_bad;

  lfsr_unmask dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_valid  (valid_in),
    .i_data   (data_in),
    .o_ready  (ready_out),
    .o_valid  (valid_out),
    .o_data   (data_out),
    .o_last   (last_out),
    .i_ready  (ready_in),
    .o_locked (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       v;
    logic [8:0] d;
    logic       rdy;
    logic       ev;
    logic [8:0] ed;
    logic       el;
    logic       elk;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst_n, input logic v, input logic [8:0] d,
                     input logic rdy, input logic ev, input logic [8:0] ed,
                     input logic el, input logic elk);
    vec_t x;
    x.rst_n = rst_n; x.v = v; x.d = d; x.rdy = rdy;
    x.ev = ev; x.ed = ed; x.el = el; x.elk = elk;
    vecs.push_back(x);
  endtask

  task automatic check(input string name, input logic [8:0] got, input logic [8:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // Drive at negedge, let one rising edge pass, sample at the next negedge.
  task automatic step(input logic rst_n, input logic v, input logic [8:0] d, input logic rdy);
    reset_n  = rst_n;
    valid_in = v;
    data_in  = d;
    ready_in = rdy;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset_n = 1'b0; valid_in = 1'b0; data_in = '0; ready_in = 1'b1;
    n_cmp = 0; n_bad = 0;

    //   rst v  data    rdy | ev ed      el lk
    // Reset state
    add(0, 0, 9'h000, 1,    0, 9'h000, 0, 0);
    // Basic frame of zeros: outputs are the mask sequence
    add(1, 1, 9'h1FF, 1,    0, 9'h000, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h087, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h10E, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h01D, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h03B, 1, 0);
    add(1, 0, 9'h000, 1,    0, 9'h03B, 0, 0);
    // Non-sync words in HUNT are dropped
    add(1, 1, 9'h055, 1,    0, 9'h03B, 0, 0);
    add(1, 1, 9'h0AA, 1,    0, 9'h03B, 0, 0);
    add(1, 1, 9'h1FF, 1,    0, 9'h03B, 0, 1);
    add(1, 1, 9'h087, 1,    1, 9'h000, 0, 1);
    add(1, 1, 9'h1FF, 1,    1, 9'h0F1, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h01D, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h03B, 1, 0);
    // Sync value as first data word is plain data
    add(1, 1, 9'h1FF, 1,    0, 9'h03B, 0, 1);
    add(1, 1, 9'h1FF, 1,    1, 9'h178, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h10E, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h01D, 0, 1);
    add(1, 1, 9'h000, 1,    1, 9'h03B, 1, 0);
    // Back-to-back frames, second reseeds
    add(1, 1, 9'h1FF, 1,    0, 9'h03B, 0, 1);
    add(1, 1, 9'h011, 1,    1, 9'h096, 0, 1);
    add(1, 1, 9'h022, 1,    1, 9'h12C, 0, 1);
    add(1, 1, 9'h033, 1,    1, 9'h02E, 0, 1);
    add(1, 1, 9'h044, 1,    1, 9'h07F, 1, 0);
    add(1, 1, 9'h1FF, 1,    0, 9'h07F, 0, 1);
    add(1, 1, 9'h100, 1,    1, 9'h187, 0, 1);
    add(1, 1, 9'h0FF, 1,    1, 9'h1F1, 0, 1);
    add(1, 1, 9'h1FF, 1,    1, 9'h1E2, 0, 1);
    add(1, 1, 9'h001, 1,    1, 9'h03A, 1, 0);
    // Reset mid-frame while o_valid is high
    add(1, 1, 9'h1FF, 1,    0, 9'h03A, 0, 1);
    add(1, 1, 9'h055, 1,    1, 9'h0D2, 0, 1);
    add(0, 1, 9'h0AA, 1,    0, 9'h000, 0, 0);
    add(1, 1, 9'h0AA, 1,    0, 9'h000, 0, 0);
    add(1, 1, 9'h123, 1,    0, 9'h000, 0, 0);
    // Reset dominates a concurrent sync word
    add(0, 1, 9'h1FF, 1,    0, 9'h000, 0, 0);
    add(1, 0, 9'h000, 1,    0, 9'h000, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].rst_n, vecs[i].v, vecs[i].d, vecs[i].rdy);
      check($sformatf("v%0d_valid", i),  9'(valid_out), 9'(vecs[i].ev));
      check($sformatf("v%0d_data", i),   data_out,      vecs[i].ed);
      check($sformatf("v%0d_last", i),   9'(last_out),  9'(vecs[i].el));
      check($sformatf("v%0d_locked", i), 9'(locked),    9'(vecs[i].elk));
    end

    // Backpressure: output held, input stalled, mask frozen.
    step(1, 1, 9'h1FF, 1);
    step(1, 1, 9'h000, 1);
    check("bp_first_data", data_out, 9'h087);
    for (int k = 0; k < 3; k++) begin
      step(1, 1, 9'h10E, 0);
      check($sformatf("bp_hold%0d_ready", k), 9'(ready_out), 9'h000);
      check($sformatf("bp_hold%0d_valid", k), 9'(valid_out), 9'h001);
      check($sformatf("bp_hold%0d_data", k),  data_out,      9'h087);
      check($sformatf("bp_hold%0d_last", k),  9'(last_out),  9'h000);
    end
    ready_in = 1'b1;
    #1;
    check("bp_release_ready", 9'(ready_out), 9'h001);
    step(1, 1, 9'h10E, 1);
    check("bp_second_valid", 9'(valid_out), 9'h001);
    check("bp_second_data", data_out, 9'h000);
    check("bp_locked", 9'(locked), 9'h001);
    step(1, 0, 9'h000, 1);
    check("bp_drain_valid", 9'(valid_out), 9'h000);
    check("bp_drain_data_hold", data_out, 9'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
